// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with level count, almost-full/almost-empty flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module sync_fifo_thresh #(
  parameter int DATA_WIDTH    = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_wr_en,
  input  logic [DATA_WIDTH-1:0]         i_wr_data,
  input  logic                          i_rd_en,
  output logic [DATA_WIDTH-1:0]         o_rd_data,
  output logic                          o_rd_valid,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_afull,
  output logic                          o_aempty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow,
  output logic                          o_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AFULL_L  = (AW+1)'(AFULL_THRESH);
  localparam logic [AW:0] AEMPTY_L = (AW+1)'(AEMPTY_THRESH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_thresh: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
    $error("sync_fifo_thresh: AFULL_THRESH out of range 1..FIFO_DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_thresh: AEMPTY_THRESH out of range 0..FIFO_DEPTH-1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_thresh: DATA_WIDTH must be >= 1");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           wr_ptr_nxt;
  logic [AW:0]           rd_ptr_nxt;
  logic [AW:0]           level_nxt;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses the registered flags, so no input reaches a flag combinationally.
  always_comb begin
    wr_acc     = i_wr_en & ~o_full;
    rd_acc     = i_rd_en & ~o_empty;
    wr_ptr_nxt = wr_ptr + (AW+1)'(wr_acc);
    rd_ptr_nxt = rd_ptr + (AW+1)'(rd_acc);
    level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_level     <= '0;
      o_full      <= 1'b0;
      o_empty     <= 1'b1;
      o_afull     <= 1'b0;
      o_aempty    <= 1'b1;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      o_level     <= level_nxt;
      o_full      <= (level_nxt == DEPTH_L);
      o_empty     <= (level_nxt == '0);
      o_afull     <= (level_nxt >= AFULL_L);
      o_aempty    <= (level_nxt <= AEMPTY_L);
      o_overflow  <= i_wr_en & o_full;
      o_underflow <= i_rd_en & o_empty;
    end
  end

  // Storage is never reset; writes during reset are suppressed so they cannot leak into new data.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign o_rd_data  = mem[rd_ptr[AW-1:0]];
  assign o_rd_valid = ~o_empty;
`else
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= rd_acc;
      if (rd_acc) begin
        o_rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Self-checking bench for sync_fifo_thresh: directed scenarios plus random traffic against a queue model.
// Honours SYNC_FIFO_FWFT_EN to select the expected read behaviour.
module tb_sync_fifo_thresh;

  localparam int DW     = 4;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;
  localparam int AEMPTY = 1;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_rd_en = 1'b0;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic          o_full;
  logic          o_empty;
  logic          o_afull;
  logic          o_aempty;
  logic [3:0]    o_level;
  logic          o_overflow;
  logic          o_underflow;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  sync_fifo_thresh #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .i_rd_en(i_rd_en), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_full(o_full),
    .o_empty(o_empty), .o_afull(o_afull), .o_aempty(o_aempty), .o_level(o_level),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: a plain queue holding the words in order.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_data = '0;
  bit            exp_valid = 1'b0;
  bit            exp_ovf = 1'b0;
  bit            exp_unf = 1'b0;

  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      q.delete();
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else begin
      automatic bit was_full  = (q.size() == DEPTH);
      automatic bit was_empty = (q.size() == 0);
      automatic bit do_pop    = i_rd_en && !was_empty;
      exp_ovf = i_wr_en && was_full;
      exp_unf = i_rd_en && was_empty;
      exp_valid = 1'b0;
      if (do_pop) begin
        exp_data  = q.pop_front();
        exp_valid = 1'b1;
      end
      if (i_wr_en && !was_full) q.push_back(i_wr_data);
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    automatic int lvl = q.size();
    cmp("level", int'(o_level), lvl);
    cmp("full", int'(o_full), int'(lvl == DEPTH));
    cmp("empty", int'(o_empty), int'(lvl == 0));
    cmp("afull", int'(o_afull), int'(lvl >= AFULL));
    cmp("aempty", int'(o_aempty), int'(lvl <= AEMPTY));
    cmp("overflow", int'(o_overflow), int'(exp_ovf));
    cmp("underflow", int'(o_underflow), int'(exp_unf));
`ifdef SYNC_FIFO_FWFT_EN
    cmp("rd_valid", int'(o_rd_valid), int'(lvl != 0));
    if (lvl != 0) cmp("rd_data", int'(o_rd_data), int'(q[0]));
`else
    cmp("rd_valid", int'(o_rd_valid), int'(exp_valid));
    cmp("rd_data", int'(o_rd_data), int'(exp_data));
`endif
  endtask

  // Compare process: outputs are stable at the falling edge.
  always @(negedge i_clk) begin
    if (check_en) checkOutput();
  end

  task automatic applyStimulus(input bit rst_n, input bit wr, input int data, input bit rd);
    i_rst_n   = rst_n;
    i_wr_en   = wr;
    i_wr_data = DW'(data);
    i_rd_en   = rd;
    @(posedge i_clk);
    #1;
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    i_rst_n = 1'b1;
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    check_en = 1'b1;
    $display("[TB] reset state");
    cmp("lit_reset_level", int'(o_level), 0);
    cmp("lit_reset_empty", int'(o_empty), 1);
    cmp("lit_reset_aempty", int'(o_aempty), 1);
    cmp("lit_reset_full", int'(o_full), 0);
    cmp("lit_reset_valid", int'(o_rd_valid), 0);

    $display("[TB] fill with 2..9");
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b1, k + 1, 1'b0);
      cmp("lit_fill_level", int'(o_level), k);
      cmp("lit_fill_aempty", int'(o_aempty), int'(k <= 1));
      cmp("lit_fill_afull", int'(o_afull), int'(k >= 6));
      cmp("lit_fill_full", int'(o_full), int'(k == 8));
    end
    applyStimulus(1'b1, 1'b1, 15, 1'b0);
    cmp("lit_overflow_pulse", int'(o_overflow), 1);
    cmp("lit_overflow_level", int'(o_level), 8);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    cmp("lit_overflow_drop", int'(o_overflow), 0);

    $display("[TB] drain");
    for (int k = 0; k < 8; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      cmp("lit_fwft_head", int'(o_rd_data), k + 2);
`endif
      applyStimulus(1'b1, 1'b0, 0, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
      cmp("lit_drain_data", int'(o_rd_data), k + 2);
      cmp("lit_drain_valid", int'(o_rd_valid), 1);
`endif
    end
    cmp("lit_drain_empty", int'(o_empty), 1);
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    cmp("lit_underflow_pulse", int'(o_underflow), 1);
    cmp("lit_underflow_valid", int'(o_rd_valid), 0);
`ifndef SYNC_FIFO_FWFT_EN
    cmp("lit_underflow_hold", int'(o_rd_data), 9);
`endif

    $display("[TB] wrap-around");
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, k, 1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 0, 1'b1);
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b1, k, 1'b0);
    cmp("lit_wrap_full", int'(o_full), 1);
    for (int k = 0; k < 8; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      cmp("lit_wrap_head", int'(o_rd_data), k);
`endif
      applyStimulus(1'b1, 1'b0, 0, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
      cmp("lit_wrap_data", int'(o_rd_data), k);
`endif
    end

    $display("[TB] simultaneous read and write");
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, k + 8, 1'b0);
    applyStimulus(1'b1, 1'b1, 12, 1'b1);
    cmp("lit_sim_level4", int'(o_level), 4);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, k, 1'b0);
    applyStimulus(1'b1, 1'b1, 5, 1'b1);
    cmp("lit_sim_full_ovf", int'(o_overflow), 1);
    cmp("lit_sim_full_level", int'(o_level), 7);
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, 1'b0, 0, 1'b1);
    applyStimulus(1'b1, 1'b1, 6, 1'b1);
    cmp("lit_sim_empty_unf", int'(o_underflow), 1);
    cmp("lit_sim_empty_level", int'(o_level), 1);
    applyStimulus(1'b1, 1'b0, 0, 1'b1);

    $display("[TB] reset mid-operation");
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, k + 1, 1'b0);
    applyStimulus(1'b0, 1'b1, 7, 1'b1);
    cmp("lit_mid_reset_level", int'(o_level), 0);
    cmp("lit_mid_reset_empty", int'(o_empty), 1);
    cmp("lit_mid_reset_valid", int'(o_rd_valid), 0);
    applyStimulus(1'b1, 1'b1, 3, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    cmp("lit_fwft_new_data", int'(o_rd_data), 3);
`endif
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    cmp("lit_mid_reset_new_data", int'(o_rd_data), 3);
`endif
    cmp("lit_mid_reset_empty_again", int'(o_empty), 1);

`ifdef SYNC_FIFO_FWFT_EN
    $display("[TB] first-word-fall-through");
    applyStimulus(1'b1, 1'b1, 10, 1'b0);
    cmp("lit_fwft_valid", int'(o_rd_valid), 1);
    cmp("lit_fwft_data", int'(o_rd_data), 10);
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    cmp("lit_fwft_pop_empty", int'(o_empty), 1);
`endif

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      automatic bit rst_n = ($urandom_range(0, 199) != 0);
      automatic int bias = (n / 500) % 3;
      automatic bit wr = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
      automatic bit rd = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
      applyStimulus(rst_n, wr, int'($urandom_range(0, 15)), rd);
    end

    @(negedge i_clk);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
